// File: rtl/life_pkg.sv
// Shared types and 1080p raster constants for the Game of Life video datapath.
package life_pkg;

  localparam int unsigned H_TOTAL      = 32'd2200;
  localparam int unsigned V_TOTAL      = 32'd1125;
  localparam int unsigned FRAME_PIXELS = H_TOTAL * V_TOTAL;

  typedef enum logic [1:0] {
    ST_WAIT_SYNC = 2'd0,
    ST_LOAD      = 2'd1,
    ST_FRAME     = 2'd2
  } seq_state_e;

  typedef enum logic [1:0] {
    MODE_COPY   = 2'd0,
    MODE_EVOLVE = 2'd1,
    MODE_SEED   = 2'd2
  } frame_mode_e;

endpackage

// File: rtl/life_frame_divider.sv
// Frames-per-generation divider and step/seed pending flags; offers the mode
// the next frame should run in.
module life_frame_divider
  import life_pkg::*;
#(
  parameter int unsigned RATE_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_frame_tick,
  input  logic              i_clear,
  input  logic              i_run_en,
  input  logic              i_step_req,
  input  logic              i_seed_req,
  input  logic [RATE_W-1:0] i_rate,
  output frame_mode_e       o_next_mode
);

  logic [RATE_W-1:0] r_div;
  logic              r_step_pend;
  logic              r_seed_pend;
  logic              w_step;
  logic              w_seed;

  // A request arriving on the frame-start cycle already counts for that frame.
  assign w_step = r_step_pend | i_step_req;
  assign w_seed = r_seed_pend | i_seed_req;

  // Mode priority: seed, free-running divider, then single step.
  always_comb begin
    o_next_mode = MODE_COPY;
    if (w_seed) begin
      o_next_mode = MODE_SEED;
    end else if (i_run_en && (r_div == i_rate)) begin
      o_next_mode = MODE_EVOLVE;
    end else if (i_run_en) begin
      o_next_mode = MODE_COPY;
    end else if (w_step) begin
      o_next_mode = MODE_EVOLVE;
    end else begin
      o_next_mode = MODE_COPY;
    end
  end

  // Divider and flags; a seed frame leaves the divider where it was.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_div       <= {RATE_W{1'b0}};
      r_step_pend <= 1'b0;
      r_seed_pend <= 1'b0;
    end else begin
      r_seed_pend <= w_seed & ~i_frame_tick;
      // While running, any pending step is dropped at the frame start.
      r_step_pend <= w_step & ~(i_frame_tick & (i_run_en | ~w_seed));
      if (!i_run_en) begin
        r_div <= {RATE_W{1'b0}};
      end else if (i_frame_tick && !w_seed) begin
        r_div <= (r_div == i_rate) ? {RATE_W{1'b0}} : r_div + RATE_W'(1);
      end else begin
        r_div <= r_div;
      end
    end
  end

endmodule

// File: rtl/life_gen_sequencer.sv
// Per-frame scheduler for the Life shift-register datapath: one registered clock
// enable plus frame-aligned mode selects, the upload window and the generation count.
module life_gen_sequencer
  import life_pkg::*;
#(
  parameter int unsigned FRAME_PIXELS = life_pkg::FRAME_PIXELS,
  parameter int unsigned CNT_W        = 22,
  parameter int unsigned RATE_W       = 4,
  parameter int unsigned GEN_W        = 16
) (
  input  logic              HDMI_CLK,
  input  logic              RESET_N,
  input  logic              frame_start_pre,
  input  logic              load_active,
  input  logic              load_wr,
  input  logic              run_en,
  input  logic              step_req,
  input  logic              seed_req,
  input  logic [RATE_W-1:0] rate,
  output logic              shift_en,
  output logic              evolve,
  output logic              seed_sel,
  output logic              load_mode,
  output logic              load_err,
  output logic [GEN_W-1:0]  gen_count
);

  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_PIXELS);

  seq_state_e       r_state;
  seq_state_e       w_state_nxt;
  logic             r_load_q;
  logic [CNT_W-1:0] r_byte_cnt;
  logic             r_shift_en;
  logic             r_evolve;
  logic             r_seed_sel;
  logic             r_load_mode;
  logic             r_load_err;
  logic [GEN_W-1:0] r_gen_count;
  logic             w_load_rise;
  logic             w_load_exit;
  logic             w_frame_tick;
  frame_mode_e      w_next_mode;

  assign w_load_rise = load_active & ~r_load_q;

  life_frame_divider #(.RATE_W(RATE_W)) u_divider (
    .i_clk        (HDMI_CLK),
    .i_rst_n      (RESET_N),
    .i_frame_tick (w_frame_tick),
    .i_clear      (w_load_exit),
    .i_run_en     (run_en),
    .i_step_req   (step_req),
    .i_seed_req   (seed_req),
    .i_rate       (rate),
    .o_next_mode  (w_next_mode)
  );

  // Next state: an upload edge beats a coincident frame start.
  always_comb begin
    w_state_nxt  = r_state;
    w_load_exit  = 1'b0;
    w_frame_tick = 1'b0;
    case (r_state)
      ST_LOAD: begin
        if (!load_active) begin
          w_state_nxt = ST_WAIT_SYNC;
          w_load_exit = 1'b1;
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_WAIT_SYNC, ST_FRAME: begin
        if (w_load_rise) begin
          w_state_nxt = ST_LOAD;
        end else if (frame_start_pre) begin
          w_state_nxt  = ST_FRAME;
          w_frame_tick = 1'b1;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: w_state_nxt = ST_WAIT_SYNC;
    endcase
  end

  // State register and upload-level history for edge detection.
  always_ff @(posedge HDMI_CLK) begin
    if (!RESET_N) begin
      r_state  <= ST_WAIT_SYNC;
      r_load_q <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_load_q <= load_active;
    end
  end

  // Registered outputs, upload byte counter and generation counter.
  always_ff @(posedge HDMI_CLK) begin
    if (!RESET_N) begin
      r_shift_en  <= 1'b0;
      r_evolve    <= 1'b0;
      r_seed_sel  <= 1'b0;
      r_load_mode <= 1'b0;
      r_load_err  <= 1'b0;
      r_gen_count <= {GEN_W{1'b0}};
      r_byte_cnt  <= {CNT_W{1'b0}};
    end else if (w_load_exit) begin
      r_shift_en  <= 1'b0;
      r_load_mode <= 1'b0;
      r_load_err  <= (r_byte_cnt != FRAME_CNT);
      r_gen_count <= {GEN_W{1'b0}};
    end else if (r_state == ST_LOAD) begin
      r_shift_en <= load_wr;
      if (load_wr && (r_byte_cnt < FRAME_CNT)) begin
        r_byte_cnt <= r_byte_cnt + CNT_W'(1);
      end else begin
        r_byte_cnt <= r_byte_cnt;
      end
    end else if (w_load_rise) begin
      r_load_mode <= 1'b1;
      r_shift_en  <= 1'b0;
      r_evolve    <= 1'b0;
      r_seed_sel  <= 1'b0;
      r_byte_cnt  <= {CNT_W{1'b0}};
    end else if (w_frame_tick) begin
      r_shift_en <= 1'b1;
      r_evolve   <= (w_next_mode == MODE_EVOLVE);
      r_seed_sel <= (w_next_mode == MODE_SEED);
      if (w_next_mode == MODE_EVOLVE) begin
        r_gen_count <= r_gen_count + GEN_W'(1);
      end else begin
        r_gen_count <= r_gen_count;
      end
    end else begin
      r_shift_en <= r_shift_en;
    end
  end

  assign shift_en  = r_shift_en;
  assign evolve    = r_evolve;
  assign seed_sel  = r_seed_sel;
  assign load_mode = r_load_mode;
  assign load_err  = r_load_err;
  assign gen_count = r_gen_count;

endmodule

// File: tb/tb_life_gen_sequencer.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a frame-level behavioural model.
module tb_life_gen_sequencer;

  localparam int FP = 16;
  localparam int CW = 5;
  localparam int RW = 4;
  localparam int GW = 16;

  logic          HDMI_CLK = 1'b0;
  logic          RESET_N;
  logic          frame_start_pre;
  logic          load_active;
  logic          load_wr;
  logic          run_en;
  logic          step_req;
  logic          seed_req;
  logic [RW-1:0] rate;
  logic          shift_en;
  logic          evolve;
  logic          seed_sel;
  logic          load_mode;
  logic          load_err;
  logic [GW-1:0] gen_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: what the outputs must be, plus the scheduling bookkeeping.
  bit m_shift, m_evolve, m_seed, m_load_mode, m_err;
  bit m_uploading, m_prev_load, m_step_wanted, m_seed_wanted;
  int m_gen, m_bytes, m_frames_waited;

  life_gen_sequencer #(
    .FRAME_PIXELS (FP),
    .CNT_W        (CW),
    .RATE_W       (RW),
    .GEN_W        (GW)
  ) dut (
    .HDMI_CLK        (HDMI_CLK),
    .RESET_N         (RESET_N),
    .frame_start_pre (frame_start_pre),
    .load_active     (load_active),
    .load_wr         (load_wr),
    .run_en          (run_en),
    .step_req        (step_req),
    .seed_req        (seed_req),
    .rate            (rate),
    .shift_en        (shift_en),
    .evolve          (evolve),
    .seed_sel        (seed_sel),
    .load_mode       (load_mode),
    .load_err        (load_err),
    .gen_count       (gen_count)
  );

  always #5 HDMI_CLK = ~HDMI_CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Apply the scheduling rules for one clock edge, from the inputs of that cycle.
  function automatic void model_clock();
    bit rise;
    if (!RESET_N) begin
      {m_shift, m_evolve, m_seed, m_load_mode, m_err} = 5'b0;
      {m_uploading, m_prev_load, m_step_wanted, m_seed_wanted} = 4'b0;
      m_gen = 0; m_bytes = 0; m_frames_waited = 0;
      return;
    end
    rise = load_active && !m_prev_load;
    m_prev_load = load_active;
    if (m_uploading && !load_active) begin
      m_uploading = 0; m_load_mode = 0; m_shift = 0;
      m_err = (m_bytes != FP);
      m_gen = 0; m_frames_waited = 0; m_step_wanted = 0; m_seed_wanted = 0;
      return;
    end
    m_step_wanted |= step_req;
    m_seed_wanted |= seed_req;
    if (m_uploading) begin
      m_shift = load_wr;
      if (load_wr && m_bytes < FP) m_bytes++;
    end else if (rise) begin
      m_uploading = 1; m_load_mode = 1; m_shift = 0; m_evolve = 0; m_seed = 0; m_bytes = 0;
    end else if (frame_start_pre) begin
      m_shift = 1; m_evolve = 0; m_seed = 0;
      if (m_seed_wanted) begin
        m_seed = 1; m_seed_wanted = 0;
      end else if (run_en) begin
        if (m_frames_waited == int'(rate)) begin
          m_evolve = 1; m_frames_waited = 0;
        end else begin
          m_frames_waited = (m_frames_waited + 1) % 16;
        end
      end else if (m_step_wanted) begin
        m_evolve = 1; m_step_wanted = 0;
      end
      if (run_en) m_step_wanted = 0;
      if (m_evolve) m_gen = (m_gen + 1) % 65536;
    end
    if (!run_en) m_frames_waited = 0;
  endfunction

  task automatic compare_all();
    chk("shift_en", shift_en, m_shift);
    chk("evolve", evolve, m_evolve);
    chk("seed_sel", seed_sel, m_seed);
    chk("load_mode", load_mode, m_load_mode);
    chk("load_err", load_err, m_err);
    chk("gen_count", gen_count, m_gen);
  endtask

  // One clock: model steps on the edge, outputs checked on the falling edge.
  task automatic cyc();
    @(posedge HDMI_CLK);
    model_clock();
    @(negedge HDMI_CLK);
    compare_all();
    frame_start_pre = 1'b0;
    step_req = 1'b0;
    seed_req = 1'b0;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0; frame_start_pre = 1'b0; load_active = 1'b0; load_wr = 1'b0;
    run_en = 1'b0; step_req = 1'b0; seed_req = 1'b0; rate = '0;
    repeat (2) cyc();
    RESET_N = 1'b1;
  endtask

  task automatic run_frame(output bit ev, output bit sd);
    frame_start_pre = 1'b1;
    cyc();
    ev = evolve;
    sd = seed_sel;
    repeat (FP - 1) cyc();
  endtask

  task automatic upload(input int nbytes);
    load_active = 1'b1;
    cyc();
    for (int i = 0; i < nbytes; i++) begin
      load_wr = 1'b1;
      cyc();
    end
    load_wr = 1'b0;
    load_active = 1'b0;
    cyc();
  endtask

  initial begin
    bit ev, sd, e1, e2, e3;
    int evolves, first_idx, last_idx;
    int pos, left;
    bit up;

    // Reset and first sync
    do_reset();
    chk("reset_shift_en", shift_en, 0);
    chk("reset_gen", gen_count, 0);
    repeat (3) cyc();
    chk("idle_shift_en", shift_en, 0);
    frame_start_pre = 1'b1;
    cyc();
    chk("sync_shift_en", shift_en, 1);
    chk("sync_evolve", evolve, 0);
    chk("sync_gen", gen_count, 0);
    repeat (FP - 1) cyc();

    // Free run at rate 2: one evolve every third frame
    run_en = 1'b1; rate = 4'd2;
    evolves = 0; first_idx = -1; last_idx = -1;
    for (int f = 0; f < 6; f++) begin
      run_frame(ev, sd);
      if (ev) begin
        evolves++;
        if (first_idx < 0) first_idx = f;
        last_idx = f;
      end
    end
    chk("rate2_evolve_frames", evolves, 2);
    chk("rate2_spacing", last_idx - first_idx, 3);
    chk("rate2_gen", gen_count, 2);

    // Single steps: two requests collapse, one on the frame-start cycle counts
    do_reset();
    frame_start_pre = 1'b1;
    cyc();
    repeat (3) cyc();
    step_req = 1'b1; cyc();
    repeat (2) cyc();
    step_req = 1'b1; cyc();
    repeat (8) cyc();
    run_frame(e1, sd);
    step_req = 1'b1;
    run_frame(e2, sd);
    run_frame(e3, sd);
    chk("step_first", e1, 1);
    chk("step_on_pulse", e2, 1);
    chk("step_none_left", e3, 0);
    chk("step_gen", gen_count, 2);

    // Seed while running does not advance the divider
    do_reset();
    run_en = 1'b1; rate = 4'd1;
    run_frame(ev, sd);
    chk("seed_pre_copy", ev, 0);
    seed_req = 1'b1;
    run_frame(ev, sd);
    chk("seed_sel_set", sd, 1);
    chk("seed_no_evolve", ev, 0);
    run_frame(ev, sd);
    chk("seed_div_held", ev, 1);

    // Upload entered mid-frame, frame pulse inside upload ignored
    frame_start_pre = 1'b1;
    cyc();
    repeat (5) cyc();
    load_active = 1'b1;
    cyc();
    chk("load_entry_mode", load_mode, 1);
    chk("load_entry_shift", shift_en, 0);
    for (int i = 0; i < FP; i++) begin
      load_wr = 1'b1;
      if (i == 8) frame_start_pre = 1'b1;
      cyc();
      chk("load_shift_follow", shift_en, 1);
      load_wr = 1'b0;
      if (i % 3 == 0) begin
        cyc();
        chk("load_shift_gap", shift_en, 0);
      end
    end
    chk("load_mode_held", load_mode, 1);
    load_active = 1'b0;
    cyc();
    chk("load_exit_mode", load_mode, 0);
    chk("load_exit_err", load_err, 0);
    chk("load_exit_gen", gen_count, 0);
    repeat (4) cyc();
    chk("wait_sync_shift", shift_en, 0);
    frame_start_pre = 1'b1;
    cyc();
    chk("resync_shift", shift_en, 1);
    repeat (FP - 1) cyc();

    // Short upload flags an error; full upload clears it
    upload(FP - 1);
    chk("short_upload_err", load_err, 1);
    upload(FP);
    chk("full_upload_err", load_err, 0);

    // Reset mid-upload, together with load_active falling
    load_active = 1'b1;
    cyc();
    repeat (3) begin load_wr = 1'b1; cyc(); end
    load_wr = 1'b0;
    RESET_N = 1'b0; load_active = 1'b0;
    cyc();
    chk("rst_load_shift", shift_en, 0);
    chk("rst_load_mode", load_mode, 0);
    chk("rst_load_err", load_err, 0);
    RESET_N = 1'b1;
    repeat (3) cyc();
    chk("rst_wait_sync", shift_en, 0);

    // Randomized run against the model
    pos = 0; up = 1'b0; left = 0; run_en = 1'b1; rate = 4'd1;
    for (int c = 0; c < 4000; c++) begin
      frame_start_pre = (pos == 0);
      pos = (pos + 1) % FP;
      if ($urandom_range(0, 99) == 0) run_en = ~run_en;
      if ($urandom_range(0, 199) == 0) rate = RW'($urandom_range(0, 3));
      step_req = ($urandom_range(0, 19) == 0);
      seed_req = ($urandom_range(0, 39) == 0);
      if (!up) begin
        load_wr = 1'b0;
        if ($urandom_range(0, 299) == 0) begin
          up = 1'b1; left = $urandom_range(13, 18); load_active = 1'b1;
        end
      end else if (left > 0) begin
        load_wr = ($urandom_range(0, 9) < 6);
        if (load_wr) left--;
      end else begin
        load_wr = 1'b0; load_active = 1'b0; up = 1'b0;
      end
      RESET_N = ($urandom_range(0, 1499) != 0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
